// File: rtl/cpu_debug_monitor_if.sv
// ---------------------------------------------------------------------------
// cpu_debug_monitor_if
// Bundle of the run-control and observation signals exchanged between the
// board-level debug controls and cpu_debug_monitor.
//   master : drives channel data/strobes and run/step/clear/display controls,
//            observes the clock enable, display, counters and done flag.
//   slave  : the monitor itself (mirror of master).
// Signals:
//   ch_data   NCH*DW  packed channel data, channel i at [i*DW +: DW]
//   ch_valid  NCH     per-channel event strobe
//   run_i, step_i, clear_i, auto_i, sel_i   run-control / display controls
//   cpu_en, disp_data, disp_ch, cycle_cnt, evt_cnt, done_o   observations
// ---------------------------------------------------------------------------
interface cpu_debug_monitor_if #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int CW  = 32,
  parameter int EW  = 16
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_valid;
  logic              run_i;
  logic              step_i;
  logic              clear_i;
  logic              auto_i;
  logic [SW-1:0]     sel_i;

  logic              cpu_en;
  logic [DW-1:0]     disp_data;
  logic [SW-1:0]     disp_ch;
  logic [CW-1:0]     cycle_cnt;
  logic [EW-1:0]     evt_cnt;
  logic              done_o;

  modport master (
    output ch_data, ch_valid, run_i, step_i, clear_i, auto_i, sel_i,
    input  cpu_en, disp_data, disp_ch, cycle_cnt, evt_cnt, done_o
  );

  modport slave (
    input  ch_data, ch_valid, run_i, step_i, clear_i, auto_i, sel_i,
    output cpu_en, disp_data, disp_ch, cycle_cnt, evt_cnt, done_o
  );
endinterface

// File: rtl/cpu_debug_monitor.sv
// ---------------------------------------------------------------------------
// cpu_debug_monitor
// Run-control and observation block between the board top level and the
// MIPS core. Gates the CPU through cpu_en (run / pause / single-step /
// cycle-limit stop), picks one of NCH debug channels for the display
// (auto-priority or manual) and keeps saturating per-channel event counters.
//
// Ports:
//   clk_CPU   block clock
//   rst_CPU   asynchronous, active-high reset
//   dbg       cpu_debug_monitor_if.slave bundle (controls, channels, outputs)
//   brk_addr  (DBG_BREAK_EN only) breakpoint address compared to channel NCH-1
//   brk_hit   (DBG_BREAK_EN only) sticky breakpoint-hit flag
//
// Optional feature macro: DBG_BREAK_EN (adds the breakpoint on channel NCH-1).
// ---------------------------------------------------------------------------
module cpu_debug_monitor #(
  parameter int NCH         = 4,
  parameter int DW          = 32,
  parameter int CW          = 32,
  parameter int EW          = 16,
  parameter int CYCLE_LIMIT = 2048
) (
  input  logic                 clk_CPU,
  input  logic                 rst_CPU,
`ifdef DBG_BREAK_EN
  input  logic [DW-1:0]        brk_addr,
  output logic                 brk_hit,
`endif
  cpu_debug_monitor_if.slave   dbg
);

  localparam int            SW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [SW-1:0] FALLBACK   = SW'(NCH - 1);
  localparam logic [CW-1:0] LIMIT_LAST = CW'(CYCLE_LIMIT - 1);
  localparam logic [EW-1:0] EVT_MAX    = {EW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          cpu_en_s;
  logic          limit_last_s;
  logic [CW-1:0] cycle_cnt_r;
  logic [EW-1:0] evt_cnt_r [NCH];
  logic [SW-1:0] auto_idx_s;
  logic          manual_ok_s;
  logic [SW-1:0] sel_idx_s;
  logic [DW-1:0] sel_data_s;
  logic [DW-1:0] disp_data_r;
  logic [SW-1:0] disp_ch_r;

  assign cpu_en_s     = (state_r == ST_RUN) || (state_r == ST_STEP);
  // The enabled cycle that brings the count to CYCLE_LIMIT is the last one.
  assign limit_last_s = (CYCLE_LIMIT != 0) && (cycle_cnt_r == LIMIT_LAST);

`ifdef DBG_BREAK_EN
  logic after_idle_r;
  logic brk_match_s;
  logic brk_hit_r;

  // Break is ignored on the first RUN cycle after IDLE so a resume from the
  // breakpoint address does not immediately re-break.
  assign brk_match_s = (dbg.ch_data[(NCH-1)*DW +: DW] == brk_addr) && !after_idle_r;

  // Remember whether the previous cycle was IDLE.
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      after_idle_r <= 1'b0;
    end else begin
      after_idle_r <= (state_r == ST_IDLE);
    end
  end

  // Sticky breakpoint-hit flag; the limit stop has priority over the break.
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      brk_hit_r <= 1'b0;
    end else if (dbg.clear_i) begin
      brk_hit_r <= 1'b0;
    end else if ((state_r == ST_RUN) && brk_match_s && !limit_last_s) begin
      brk_hit_r <= 1'b1;
    end else begin
      brk_hit_r <= brk_hit_r;
    end
  end

  assign brk_hit = brk_hit_r;
`endif

  // Run-control state register.
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: clear > limit > break > run/step.
  always_comb begin
    state_nxt_s = state_r;
    if (dbg.clear_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (dbg.run_i) begin
            state_nxt_s = ST_RUN;
          end else if (dbg.step_i) begin
            state_nxt_s = ST_STEP;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (limit_last_s) begin
            state_nxt_s = ST_DONE;
`ifdef DBG_BREAK_EN
          end else if (brk_match_s) begin
            state_nxt_s = ST_IDLE;
`endif
          end else if (!dbg.run_i) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_STEP: begin
          if (limit_last_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Enabled-cycle counter; wraps naturally when the limit is disabled.
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      cycle_cnt_r <= {CW{1'b0}};
    end else if (dbg.clear_i) begin
      cycle_cnt_r <= {CW{1'b0}};
    end else if (cpu_en_s) begin
      cycle_cnt_r <= cycle_cnt_r + CW'(1);
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  // Saturating per-channel event counters.
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      for (int i = 0; i < NCH; i++) begin
        evt_cnt_r[i] <= {EW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (dbg.clear_i) begin
          evt_cnt_r[i] <= {EW{1'b0}};
        end else if (cpu_en_s && dbg.ch_valid[i] && (evt_cnt_r[i] != EVT_MAX)) begin
          evt_cnt_r[i] <= evt_cnt_r[i] + EW'(1);
        end else begin
          evt_cnt_r[i] <= evt_cnt_r[i];
        end
      end
    end
  end

  // Display channel selection. Auto: lowest active channel below the fallback,
  // scanned from the top so the lowest index wins. Manual: out-of-range
  // selects fall back to the PC channel.
  always_comb begin
    auto_idx_s = FALLBACK;
    for (int i = NCH - 2; i >= 0; i--) begin
      auto_idx_s = dbg.ch_valid[i] ? SW'(i) : auto_idx_s;
    end
    manual_ok_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      manual_ok_s = manual_ok_s | (dbg.sel_i == SW'(i));
    end
    if (dbg.auto_i) begin
      sel_idx_s = auto_idx_s;
    end else if (manual_ok_s) begin
      sel_idx_s = dbg.sel_i;
    end else begin
      sel_idx_s = FALLBACK;
    end
    sel_data_s = {DW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      sel_data_s = (sel_idx_s == SW'(i)) ? dbg.ch_data[i*DW +: DW] : sel_data_s;
    end
  end

  // Display registers follow executed cycles only, freezing while paused.
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      disp_data_r <= {DW{1'b0}};
      disp_ch_r   <= {SW{1'b0}};
    end else if (cpu_en_s) begin
      disp_data_r <= sel_data_s;
      disp_ch_r   <= sel_idx_s;
    end else begin
      disp_data_r <= disp_data_r;
      disp_ch_r   <= disp_ch_r;
    end
  end

  assign dbg.cpu_en    = cpu_en_s;
  assign dbg.done_o    = (state_r == ST_DONE);
  assign dbg.cycle_cnt = cycle_cnt_r;
  assign dbg.disp_data = disp_data_r;
  assign dbg.disp_ch   = disp_ch_r;
  assign dbg.evt_cnt   = evt_cnt_r[disp_ch_r];

endmodule
